// File: rtl/prescaled_counter.sv
// Up/down modulo counter stepped by an internal enable prescaler, all in the clk domain.
// Optional PRESCALED_COUNTER_SATURATE_EN: hold at the range limit instead of wrapping.
module prescaled_counter #(
   parameter int WIDTH  = 4,
   parameter int DIV    = 4,
   parameter int MODULO = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tick,
   output logic             tc
);

   localparam int               PW       = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
   localparam logic [WIDTH-1:0] CNT_MAX  = WIDTH'(MODULO - 1);

   logic [PW-1:0]    pre_q, pre_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tick_q, tick_d;
   logic             tc_q, tc_d;
   logic             step;
   logic             at_limit;

   assign step     = en && (pre_q == PRE_LAST);
   assign at_limit = up ? (count_q == CNT_MAX) : (count_q == '0);

   always_comb begin
      pre_d   = pre_q;
      count_d = count_q;
      tick_d  = 1'b0;
      tc_d    = 1'b0;
      if (load) begin
         // Out-of-range load values clamp so count never leaves 0..MODULO-1
         count_d = (load_val > CNT_MAX) ? CNT_MAX : load_val;
         pre_d   = '0;
      end else if (step) begin
         pre_d  = '0;
         tick_d = 1'b1;
         tc_d   = at_limit;
         if (at_limit) begin
`ifdef PRESCALED_COUNTER_SATURATE_EN
            count_d = count_q;
`else
            count_d = up ? '0 : CNT_MAX;
`endif
         end else begin
            count_d = up ? count_q + 1'b1 : count_q - 1'b1;
         end
      end else if (en) begin
         pre_d = pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q   <= '0;
         count_q <= '0;
         tick_q  <= 1'b0;
         tc_q    <= 1'b0;
      end else begin
         pre_q   <= pre_d;
         count_q <= count_d;
         tick_q  <= tick_d;
         tc_q    <= tc_d;
      end
   end

   assign count = count_q;
   assign tick  = tick_q;
   assign tc    = tc_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Scoreboard bench for prescaled_counter (WIDTH=4, DIV=4, MODULO=10).
module tb_prescaled_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic [3:0] count;
   logic       tick;
   logic       tc;

   int nvec = 0;
   int nerr = 0;
   int cyc  = 0;

   typedef struct {
      int         at;
      logic [3:0] cnt;
      logic       tc;
   } exp_t;

   exp_t q[$];

   prescaled_counter #(.WIDTH(4), .DIV(4), .MODULO(10)) dut (
      .clk(clk), .rst(rst), .en(en), .up(up), .load(load),
      .load_val(load_val), .count(count), .tick(tick), .tc(tc)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input int at, input int cnt, input bit t);
      exp_t e;
      e.at  = at;
      e.cnt = 4'(cnt);
      e.tc  = t;
      q.push_back(e);
   endtask

   task automatic chk(input string name, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; load = 1'b0; up = 1'b1;
      wait_n(1);
      chk("reset_count", int'(count), 0);
      chk("reset_tick", int'(tick), 0);
      chk("reset_tc", int'(tc), 0);
      rst = 1'b0;
   endtask

   // Monitor: every tick consumes one expected step; late or missing ticks are reported
   always @(negedge clk) begin
      exp_t e;
      if (tick === 1'b1) begin
         nvec++;
         if (q.size() == 0) begin
            nerr++;
            $display("FAIL unexpected_tick: cycle %0d count %0d tc %b", cyc, count, tc);
         end else begin
            e = q.pop_front();
            if (e.at != cyc || count !== e.cnt || tc !== e.tc) begin
               nerr++;
               $display("FAIL step: got cycle %0d count %0d tc %b, expected cycle %0d count %0d tc %b",
                        cyc, count, tc, e.at, e.cnt, e.tc);
            end
         end
      end else begin
         if (tc === 1'b1) begin
            nvec++;
            nerr++;
            $display("FAIL tc_without_tick: cycle %0d", cyc);
         end
         if (q.size() > 0 && q[0].at <= cyc) begin
            e = q.pop_front();
            nvec++;
            nerr++;
            $display("FAIL missed_tick: got no tick at cycle %0d, expected count %0d", e.at, e.cnt);
         end
      end
   end

   initial begin
      int c;
      wait_n(2);

      // Continuous up count: 11 steps over 44 cycles, single wrap 9 -> 0
      do_reset();
      en = 1'b1; up = 1'b1;
      c = cyc;
      for (int k = 1; k <= 11; k++) push(c + 4 * k, k % 10, k == 10);
      wait_n(44);
      chk("up_run_end_count", int'(count), 1);
      en = 1'b0;

      // Down count from reset wraps to 9 on the first step
      do_reset();
      en = 1'b1; up = 1'b0;
      c = cyc;
      for (int k = 1; k <= 5; k++) push(c + 4 * k, 10 - k, k == 1);
      wait_n(20);
      en = 1'b0;

      // en on every other cycle doubles the step period
      do_reset();
      up = 1'b1;
      c = cyc;
      for (int k = 1; k <= 12; k++) push(c + 8 * k - 1, k % 10, k == 10);
      for (int i = 0; i < 96; i++) begin
         en = (i % 2 == 0);
         wait_n(1);
      end
      en = 1'b0;

      // Load over a due step: clamped to 9, no tick, prescaler restarts
      do_reset();
      en = 1'b1; up = 1'b1;
      wait_n(3);
      load = 1'b1; load_val = 4'd13;
      wait_n(1);
      chk("load_clamp_count", int'(count), 9);
      chk("load_no_tick", int'(tick), 0);
      load = 1'b0;
      c = cyc;
      push(c + 4, 0, 1'b1);
      wait_n(4);
      en = 1'b0;

      // Load is honoured with en low
      load = 1'b1; load_val = 4'd6;
      wait_n(1);
      chk("load_en_low_count", int'(count), 6);
      load = 1'b0;
      wait_n(3);
      chk("hold_en_low_count", int'(count), 6);

      // Reset mid-period (count 5, pre 2) discards the prescaler phase
      do_reset();
      en = 1'b1; up = 1'b1;
      c = cyc;
      for (int k = 1; k <= 5; k++) push(c + 4 * k, k, 1'b0);
      wait_n(22);
      chk("pre_reset_count", int'(count), 5);
      rst = 1'b1;
      wait_n(1);
      chk("midrst_count", int'(count), 0);
      chk("midrst_tick", int'(tick), 0);
      chk("midrst_tc", int'(tc), 0);
      rst = 1'b0;
      c = cyc;
      push(c + 4, 1, 1'b0);
      wait_n(4);
      en = 1'b0;

      // Up from the top limit, then down from the bottom limit
      load = 1'b1; load_val = 4'd9;
      wait_n(1);
      load = 1'b0; en = 1'b1; up = 1'b1;
      c = cyc;
`ifdef PRESCALED_COUNTER_SATURATE_EN
      push(c + 4, 9, 1'b1);
      push(c + 8, 9, 1'b1);
`else
      push(c + 4, 0, 1'b1);
      push(c + 8, 1, 1'b0);
`endif
      wait_n(8);
      en = 1'b0;
      load = 1'b1; load_val = 4'd0;
      wait_n(1);
      load = 1'b0; en = 1'b1; up = 1'b0;
      c = cyc;
`ifdef PRESCALED_COUNTER_SATURATE_EN
      push(c + 4, 0, 1'b1);
      push(c + 8, 0, 1'b1);
`else
      push(c + 4, 9, 1'b1);
      push(c + 8, 8, 1'b0);
`endif
      wait_n(8);
      en = 1'b0;

      wait_n(6);
      chk("scoreboard_drained", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/prescaled_counter.md
# prescaled_counter

Parametrised successor to the board-level counter path. It counts on a prescaled enable tick derived inside the single system clock domain, with no generated or divided clock. It supports up/down counting, an arbitrary modulo, synchronous load and a terminal-count pulse, and it drives the board LED/count outputs directly from `clk`.

## Interface
- `WIDTH`, 4: count width in bits.
- `DIV`, 4: prescale ratio; one count step per `DIV` enabled cycles; legal range ≥ 1.
- `MODULO`, 16: count range is 0..`MODULO`-1; legal range 2 ≤ `MODULO` ≤ 2^`WIDTH`.
- `clk` in 1: system clock; sole clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: prescaler/count enable; low freezes prescaler and count.
- `up` in 1: direction; 1 = increment, 0 = decrement; sampled on step cycles.
- `load` in 1: synchronous load strobe.
- `load_val` in `WIDTH`: value loaded on `load`.
- `count` out `WIDTH`: current count, registered.
- `tick` out 1: one-cycle pulse, registered, coincident with each count step.
- `tc` out 1: one-cycle pulse, registered; step taken at the range limit in the current direction.

## Operation
- Internal prescaler `pre` has width ceil(log2(`DIV`)), minimum 1.
- `step` = `en` && (`pre` == `DIV`-1), combinational and internal.
- Priority per edge is `rst` > `load` > `step` > hold.
- On `rst`:
  - `pre`=0, `count`=0, `tick`=0, `tc`=0.
  - `rst` mid-count discards the prescaler phase.
- On `load`:
  - `count` = min(`load_val`, `MODULO`-1).
  - `pre`=0; `tick`=0, `tc`=0.
  - `load` is honoured regardless of `en`.
- On `step` (no load):
  - `pre`=0, `tick`=1.
  - `up`=1: `count`<`MODULO`-1 → +1; `count`==`MODULO`-1 → 0, `tc`=1.
  - `up`=0: `count`>0 → −1; `count`==0 → `MODULO`-1, `tc`=1.
- `en`=1, no step: `pre`+1; `count` holds; `tick`=0, `tc`=0.
- `en`=0: `pre` and `count` hold; `tick`=0, `tc`=0.
- `DIV`=1: `step` on every enabled cycle.
- Direction change takes effect on the next step; no prescaler reset.
- All arithmetic is modulo-limited as above. `count` never exceeds `MODULO`-1.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Step latency: with `en` held high from a fresh `pre`=0, the first `count` change and `tick` appear `DIV` edges later, then every `DIV` edges.
- `tick` and `tc` are high for exactly one cycle, in the same cycle the new `count` is visible.
- `load` takes 1 edge. The next step comes `DIV` enabled edges after the load edge.
- Deasserting `en` for N cycles stretches the step period by exactly N cycles.

## Configuration
- `PRESCALED_COUNTER_SATURATE_EN`:
  - Defined: at the limit, a step holds `count` at `MODULO`-1 (up) or 0 (down) instead of wrapping. `tick` and `tc` still pulse on that step.
  - Undefined: wrap-around behaviour as in Operation.
  - Load, reset and prescaler behaviour are identical either way.

## Test plan
All scenarios use `WIDTH`=4, `DIV`=4, `MODULO`=10.
- Reset, then `en`=1, `up`=1 for 44 cycles → `count` reads 0,1,…,9,0,1 stepping every 4 cycles. `tick` pulses 11 times. `tc` pulses once, with `count`=0 after 9.
- `up`=0 from reset → first step gives `count`=9 with `tc`=1, then 8,7,… on each step.
- `en` toggled 1-of-2 cycles → step period 8 cycles; `count` is identical to the continuous run at every step.
- `load`=1 with `load_val`=13 while `step` is due → `count`=9, no `tick`. The next step is 4 enabled cycles later, with `tc`=1 and `count`=0.
- `rst` asserted mid-period with `count`=5 and `pre`=2 → next cycle `count`=0 and all pulses 0. The first step comes 4 cycles after `rst` is released.
- With `PRESCALED_COUNTER_SATURATE_EN` defined, `up`=1 from `count`=9 → `count` stays 9 on each step, with `tick`=1 and `tc`=1 per step.
